// File: rtl/mem_io_responder.sv
// Responder side of the CPU byte bus: 128KB byte RAM, I/O page at 0x3xxxx with
// UART TX FIFO, one-byte RX holding register and a free-running cycle counter.
module mem_io_responder #(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done,
    output logic        tx_overflow
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(TX_DEPTH - FULL_MARGIN);

    logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];
    logic [7:0] fifo [0:TX_DEPTH-1];

    logic [7:0]    ram_q;
    logic          rd_ram;
    logic [7:0]    io_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          rx_full;
    logic [7:0]    rx_reg;
    logic [31:0]   cnt, snapshot;

    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [2:0] off;
    logic ram_sel, io_sel, io_rd, io_wr;
    logic push_req, push_ok, pop, capture;
    logic [7:0] io_rdata;

    assign ram_idx = mem_a[RAM_ADDR_W-1:0];
    assign off     = mem_a[2:0];
    assign ram_sel = ~mem_a[17];
    assign io_sel  = mem_a[17] & mem_a[16];
    assign io_rd   = io_sel & ~mem_wr;
    assign io_wr   = io_sel & mem_wr;

    // Zero bytes are the bus idiom for "nothing to send" and never enter the FIFO.
    assign push_req = io_wr && off == 3'd0 && mem_dout != 8'h00;
    assign pop      = tx_valid & tx_ready;
    assign push_ok  = push_req && (count < DEPTH_C || pop);
    assign capture  = rx_valid & ~rx_full;

    assign tx_valid = count != '0;
    assign tx_data  = fifo[rd_ptr];
    assign rx_ready = ~rx_full;
    assign mem_din  = rd_ram ? ram_q : io_q;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push_ok)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        io_rdata = 8'h00;
        case (off)
            3'd0:    io_rdata = rx_full ? rx_reg : 8'h00;
            3'd4:    io_rdata = cnt[7:0];
            3'd5:    io_rdata = snapshot[15:8];
            3'd6:    io_rdata = snapshot[23:16];
            3'd7:    io_rdata = snapshot[31:24];
            default: io_rdata = 8'h00;
        endcase
    end

    // Storage arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk_in) begin
        if (ram_sel && mem_wr)
            ram[ram_idx] <= mem_dout;
        ram_q <= ram[ram_idx];
        if (push_ok)
            fifo[wr_ptr] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_ram         <= 1'b0;
            io_q           <= 8'h00;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            program_done   <= 1'b0;
            rx_full        <= 1'b0;
            rx_reg         <= 8'h00;
            cnt            <= 32'd0;
            snapshot       <= 32'd0;
        end else begin
            rd_ram <= ram_sel & ~mem_wr;
            io_q   <= io_rd ? io_rdata : 8'h00;
            cnt    <= cnt + 32'd1;
            count  <= count_nxt;
            io_buffer_full <= count_nxt >= THRESH_C;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push_ok)
                tx_overflow <= 1'b1;
            if (io_wr && off == 3'd4)
                program_done <= 1'b1;
            // The high bytes read later come from this snapshot so all four agree.
            if (io_rd && off == 3'd4)
                snapshot <= cnt;
            if (capture) begin
                rx_full <= 1'b1;
                rx_reg  <= rx_data;
            end else if (io_rd && off == 3'd0) begin
                rx_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, unmapped space, TX FIFO, RX register,
// cycle counter snapshot and reset behaviour.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;
    logic        tx_overflow;

    int vectors = 0;
    int errors  = 0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_done(program_done), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    localparam logic [31:0] IDLE = 32'h0002_0000;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] data);
        mem_wr = 1'b1; mem_a = addr; mem_dout = data;
        step();
        mem_wr = 1'b0; mem_a = IDLE; mem_dout = 8'h00;
    endtask

    task automatic rd(input logic [31:0] addr);
        mem_wr = 1'b0; mem_a = addr;
        step();
        mem_a = IDLE;
    endtask

    initial begin
        rst_in = 1'b0; mem_a = IDLE; mem_dout = 8'h00; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        step(); step();
        check("rst_mem_din", 32'(mem_din), 32'h00);
        check("rst_full", 32'(io_buffer_full), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        check("rst_done", 32'(program_done), 32'h0);
        check("rst_ovf", 32'(tx_overflow), 32'h0);
        rst_in = 1'b1;

        // RAM write then read-back, low and top address
        wr(32'h0000_0100, 8'hA5);
        rd(32'h0000_0100);
        check("ram_100", 32'(mem_din), 32'hA5);
        wr(32'h0001_FFFF, 8'h3C);
        rd(32'h0001_FFFF);
        check("ram_1ffff", 32'(mem_din), 32'h3C);
        rd(32'h0000_0100);
        check("ram_100_again", 32'(mem_din), 32'hA5);

        // unmapped region
        wr(32'h0002_0010, 8'h77);
        rd(32'h0002_0010);
        check("unmapped_rd", 32'(mem_din), 32'h00);

        // TX stream with zero byte filtered
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h41);
        check("tx_first_valid", 32'(tx_valid), 32'h1);
        check("tx_first_data", 32'(tx_data), 32'h41);
        wr(32'h0003_0000, 8'h00);
        check("tx_zero_dropped", 32'(tx_valid), 32'h0);
        wr(32'h0003_0000, 8'h42);
        check("tx_second_data", 32'(tx_data), 32'h42);
        step();
        check("tx_drained", 32'(tx_valid), 32'h0);
        check("tx_no_ovf", 32'(tx_overflow), 32'h0);

        // fill FIFO to threshold, full, and overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 13; i++) wr(32'h0003_0000, 8'(i));
        check("full_at_13", 32'(io_buffer_full), 32'h0);
        wr(32'h0003_0000, 8'd14);
        check("full_at_14", 32'(io_buffer_full), 32'h1);
        wr(32'h0003_0000, 8'd15);
        wr(32'h0003_0000, 8'd16);
        check("ovf_at_16", 32'(tx_overflow), 32'h0);
        wr(32'h0003_0000, 8'h99);
        check("ovf_at_17", 32'(tx_overflow), 32'h1);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(tx_data), 32'(i));
            step();
        end
        check("drain_empty", 32'(tx_valid), 32'h0);
        check("drain_full_clr", 32'(io_buffer_full), 32'h0);
        check("ovf_sticky", 32'(tx_overflow), 32'h1);

        // RX holding register
        rx_valid = 1'b1; rx_data = 8'h5A;
        step();
        rx_valid = 1'b0;
        check("rx_busy", 32'(rx_ready), 32'h0);
        rd(32'h0003_0000);
        check("rx_read", 32'(mem_din), 32'h5A);
        check("rx_freed", 32'(rx_ready), 32'h1);
        rd(32'h0003_0000);
        check("rx_empty_read", 32'(mem_din), 32'h00);
        rx_valid = 1'b1; rx_data = 8'h77;
        rd(32'h0003_0000);
        rx_valid = 1'b0;
        check("rx_same_cycle_old", 32'(mem_din), 32'h00);
        check("rx_same_cycle_kept", 32'(rx_ready), 32'h0);
        rd(32'h0003_0000);
        check("rx_same_cycle_new", 32'(mem_din), 32'h77);
        rd(32'h0003_0002);
        check("io_other_off", 32'(mem_din), 32'h00);

        // program_done and mid-stream reset
        tx_ready = 1'b0;
        wr(32'h0003_0000, 8'h55);
        wr(32'h0003_0004, 8'h01);
        check("done_set", 32'(program_done), 32'h1);
        check("done_no_push", 32'(tx_data), 32'h55);
        step(); step(); step();
        check("done_sticky", 32'(program_done), 32'h1);
        rd(32'h0000_0100);
        check("pre_rst_ram", 32'(mem_din), 32'hA5);
        rst_in = 1'b0; mem_a = 32'h0000_0100;
        step();
        check("mid_rst_mem_din", 32'(mem_din), 32'h00);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_done", 32'(program_done), 32'h0);
        check("mid_rst_ovf", 32'(tx_overflow), 32'h0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
        mem_a = IDLE;
        rst_in = 1'b1;

        // counter: 1000 edges out of reset, then the read edge sees 1000 = 0x3E8
        repeat (1000) step();
        rd(32'h0003_0004);
        check("cnt_b0", 32'(mem_din), 32'hE8);
        rd(32'h0003_0005);
        check("cnt_b1", 32'(mem_din), 32'h03);
        rd(32'h0003_0006);
        check("cnt_b2", 32'(mem_din), 32'h00);
        rd(32'h0003_0007);
        check("cnt_b3", 32'(mem_din), 32'h00);
        step(); step();
        rd(32'h0003_0005);
        check("cnt_b1_coherent", 32'(mem_din), 32'h03);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
